mem_io_arbiter: RTL and testbench

// Two-master arbiter and sequencer for the shared data-memory / memory-mapped-IO port.
// M0 is the CPU load/store path; M1 is the UART program/data loader.

---
 rtl/mem_io_arbiter_if.sv | 50 +++++
 rtl/mem_io_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_io_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_arbiter_if.sv
// Shared request/grant/ack bundle for the two masters plus the memory/IO bus strobes.
// Latency: none, wires only.
// Backpressure: each master holds req and its fields until its gnt pulse.
interface mem_io_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic        m0_re;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic        m1_re;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    logic        bus_MemRead;
    logic        bus_MemWrite;
    logic        bus_ioRead;
    logic        bus_ioWrite;
    logic [31:0] bus_addr;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;

    // Arbiter side: receives requests, drives grants and the shared bus.
    modport slave (
        input  m0_req, m0_we, m0_re, m0_addr, m0_wdata,
        output m0_gnt, m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_re, m1_addr, m1_wdata,
        output m1_gnt, m1_ack, m1_rdata,
        output bus_MemRead, bus_MemWrite, bus_ioRead, bus_ioWrite, bus_addr, bus_din,
        input  bus_dout
    );

    // Requestor / memory side.
    modport master (
        output m0_req, m0_we, m0_re, m0_addr, m0_wdata,
        input  m0_gnt, m0_ack, m0_rdata,
        output m1_req, m1_we, m1_re, m1_addr, m1_wdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  bus_MemRead, bus_MemWrite, bus_ioRead, bus_ioWrite, bus_addr, bus_din,
        output bus_dout
    );
endinterface

// File: rtl/mem_io_arbiter.sv
// Two-master arbiter/sequencer for the shared data-memory / memory-mapped-IO port.
// Latency: sampled req to ack is 2 cycles (write, IO read, no-op) or 2+RD_LAT (memory read).
// Backpressure: one transaction in flight; requests wait in IDLE. MEMIO_ARB_PERF_EN adds ack counters.
module mem_io_arbiter #(
    parameter int          RD_LAT    = 1,
    parameter logic [15:0] IO_HI     = 16'hFFFF,
    parameter int          PRIO_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    mem_io_arbiter_if.slave bus,
    output logic            busy
`ifdef MEMIO_ARB_PERF_EN
    ,
    output logic [15:0]     perf_m0,
    output logic [15:0]     perf_m1
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        winner, rr_last;
    logic        lat_we, lat_re, lat_io;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] rdata0, rdata1;
    logic [2:0]  wait_cnt;

    logic        pick;
    logic        sel_we, sel_re;
    logic [31:0] sel_addr, sel_wdata;
    logic        capture, is_mem_rd, wait_done;
    logic        rd_load;
    logic [31:0] rd_val;
    logic        ack0, ack1;

    // Winner selection and field mux for the request being sampled in IDLE.
    always_comb begin
        pick = 1'b0;
        if (bus.m0_req && bus.m1_req)
            pick = (PRIO_MODE != 0) ? 1'b0 : ~rr_last;
        else
            pick = ~bus.m0_req;
        sel_we    = pick ? bus.m1_we    : bus.m0_we;
        sel_re    = pick ? bus.m1_re    : bus.m0_re;
        sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    assign is_mem_rd = ~lat_we & lat_re & ~lat_io;
    assign wait_done = (wait_cnt == 3'(RD_LAT - 1));
    assign capture   = (state == IDLE) & (bus.m0_req | bus.m1_req);

    // State register; reset drops everything in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus all strobes, grants and acks decoded from the current state.
    always_comb begin
        state_nxt        = state;
        bus.bus_MemRead  = 1'b0;
        bus.bus_MemWrite = 1'b0;
        bus.bus_ioRead   = 1'b0;
        bus.bus_ioWrite  = 1'b0;
        bus.m0_gnt       = 1'b0;
        bus.m1_gnt       = 1'b0;
        ack0             = 1'b0;
        ack1             = 1'b0;
        rd_load          = 1'b0;
        rd_val           = lat_re ? bus.bus_dout : 32'd0;
        case (state)
            IDLE: begin
                if (capture) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.m0_gnt       = ~winner;
                bus.m1_gnt       = winner;
                bus.bus_MemWrite = lat_we & ~lat_io;
                bus.bus_ioWrite  = lat_we & lat_io;
                bus.bus_ioRead   = ~lat_we & lat_re & lat_io;
                bus.bus_MemRead  = is_mem_rd;
                // IO reads and no-ops complete here; writes leave rdata untouched.
                rd_load          = ~lat_we & ~is_mem_rd;
                state_nxt        = is_mem_rd ? WAIT : RESP;
            end
            WAIT: begin
                bus.bus_MemRead = 1'b1;
                if (wait_done) begin
                    rd_load   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ack0      = ~winner;
                ack1      = winner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture of the winning request, read-latency counter and per-master read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner    <= 1'b0;
            rr_last   <= 1'b1;
            lat_we    <= 1'b0;
            lat_re    <= 1'b0;
            lat_io    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            wait_cnt  <= 3'd0;
            rdata0    <= 32'd0;
            rdata1    <= 32'd0;
        end else begin
            if (capture) begin
                winner    <= pick;
                rr_last   <= pick;
                lat_we    <= sel_we;
                lat_re    <= sel_re;
                lat_io    <= (sel_addr[31:16] == IO_HI);
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (state == ISSUE)     wait_cnt <= 3'd0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
            if (rd_load && !winner) rdata0 <= rd_val;
            if (rd_load && winner)  rdata1 <= rd_val;
        end
    end

    assign bus.m0_ack   = ack0;
    assign bus.m1_ack   = ack1;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
    assign bus.bus_addr = lat_addr;
    assign bus.bus_din  = lat_wdata;
    assign busy         = (state != IDLE);

`ifdef MEMIO_ARB_PERF_EN
    // Saturating per-master completion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_m0 <= 16'd0;
            perf_m1 <= 16'd0;
        end else begin
            if (ack0 && perf_m0 != 16'hFFFF) perf_m0 <= perf_m0 + 16'd1;
            if (ack1 && perf_m1 != 16'hFFFF) perf_m1 <= perf_m1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_io_arbiter.sv
module tb_mem_io_arbiter;
    localparam int          RD_LAT    = 2;
    localparam logic [15:0] IO_HI     = 16'hFFFF;
    localparam int          PRIO_MODE = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    mem_io_arbiter_if bus_if ();
`ifdef MEMIO_ARB_PERF_EN
    logic [15:0] perf_m0, perf_m1;
`endif

    mem_io_arbiter #(.RD_LAT(RD_LAT), .IO_HI(IO_HI), .PRIO_MODE(PRIO_MODE)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if.slave),
        .busy (busy)
`ifdef MEMIO_ARB_PERF_EN
        ,
        .perf_m0 (perf_m0),
        .perf_m1 (perf_m1)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // transaction-level model state
    bit          active;
    int          t0, dur;
    bit          w, k_we, k_re, k_io;
    bit          rr_last;
    logic [31:0] h_addr, h_din;
    logic [31:0] exp_rd [2];
    int          perf_exp [2];
    logic [31:0] hist [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // {busy, m0_gnt, m1_gnt, m0_ack, m1_ack, MemRead, MemWrite, ioRead, ioWrite}
    function automatic logic [8:0] ctrl_vec();
        return {busy, bus_if.m0_gnt, bus_if.m1_gnt, bus_if.m0_ack, bus_if.m1_ack,
                bus_if.bus_MemRead, bus_if.bus_MemWrite, bus_if.bus_ioRead, bus_if.bus_ioWrite};
    endfunction

    // Evaluate one cycle of the model: compare, then decide what the arbiter samples.
    task automatic model_eval();
        int d;
        bit idle_now, rd, r0, r1;
        logic [8:0] e;
        if (rst) begin
            active = 0; h_addr = 0; h_din = 0; rr_last = 1;
            exp_rd[0] = 0; exp_rd[1] = 0; perf_exp[0] = 0; perf_exp[1] = 0;
        end else begin
            hist[cyc % 16] = bus_if.bus_dout;
            idle_now = !active;
            d  = cyc - t0;
            rd = !k_we && k_re;
            if (active && d == dur) begin
                if (!k_we)
                    exp_rd[w] = !k_re ? 32'd0 : (k_io ? hist[(t0 + 1) % 16] : hist[(t0 + 1 + RD_LAT) % 16]);
                if (perf_exp[w] < 65535) perf_exp[w]++;
            end
            e = {active,
                 active && d == 1 && !w, active && d == 1 && w,
                 active && d == dur && !w, active && d == dur && w,
                 active && rd && !k_io && d <= 1 + RD_LAT,
                 active && d == 1 && k_we && !k_io,
                 active && d == 1 && rd && k_io,
                 active && d == 1 && k_we && k_io};
            chk("m_ctrl", 64'(ctrl_vec()), 64'(e));
            chk("m_rdata0", 64'(bus_if.m0_rdata), 64'(exp_rd[0]));
            chk("m_rdata1", 64'(bus_if.m1_rdata), 64'(exp_rd[1]));
            chk("m_addr_din", {bus_if.bus_addr, bus_if.bus_din}, {h_addr, h_din});
`ifdef MEMIO_ARB_PERF_EN
            chk("m_perf", 64'({perf_m0, perf_m1}), 64'({16'(perf_exp[0]), 16'(perf_exp[1])}));
`endif
            if (active && d == dur) active = 0;
            r0 = bus_if.m0_req;
            r1 = bus_if.m1_req;
            if (idle_now && (r0 || r1)) begin
                if (r0 && r1) w = (PRIO_MODE != 0) ? 1'b0 : !rr_last;
                else          w = r1;
                rr_last = w;
                k_we   = w ? bus_if.m1_we : bus_if.m0_we;
                k_re   = w ? bus_if.m1_re : bus_if.m0_re;
                h_addr = w ? bus_if.m1_addr : bus_if.m0_addr;
                h_din  = w ? bus_if.m1_wdata : bus_if.m0_wdata;
                k_io   = (h_addr[31:16] == IO_HI);
                dur    = (!k_we && k_re && !k_io) ? 2 + RD_LAT : 2;
                t0     = cyc;
                active = 1;
            end
        end
        cyc++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic r, input logic we, input logic re,
                           input logic [31:0] a, input logic [31:0] wd);
        if (m == 0) begin
            bus_if.m0_req = r; bus_if.m0_we = we; bus_if.m0_re = re;
            bus_if.m0_addr = a; bus_if.m0_wdata = wd;
        end else begin
            bus_if.m1_req = r; bus_if.m1_we = we; bus_if.m1_re = re;
            bus_if.m1_addr = a; bus_if.m1_wdata = wd;
        end
    endtask

    task automatic rand_master(input int m);
        logic g, r;
        logic [31:0] a;
        g = (m == 0) ? bus_if.m0_gnt : bus_if.m1_gnt;
        r = (m == 0) ? bus_if.m0_req : bus_if.m1_req;
        if (!r || g) begin
            if ($urandom_range(0, 2) != 0) begin
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a[31:16] = IO_HI;
                drive_m(m, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            end else begin
                drive_m(m, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end else if ($urandom_range(0, 15) == 0) begin
            drive_m(m, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
    endtask

    initial begin
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        bus_if.bus_dout = 32'd0;

        // reset state
        run_cycle();
        run_cycle();
        chk("reset_ctrl", 64'(ctrl_vec()), 64'd0);
        chk("reset_rdata", {bus_if.m0_rdata, bus_if.m1_rdata}, 64'd0);
        chk("reset_addr_din", {bus_if.bus_addr, bus_if.bus_din}, 64'd0);
        rst = 1'b0;
        run_cycle();

        // 1: M0 memory write
        drive_m(0, 1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
        run_cycle();
        chk("t1_issue", 64'(ctrl_vec()), 64'(9'b1_10_00_0100));
        chk("t1_addr_din", {bus_if.bus_addr, bus_if.bus_din}, {32'h0000_0010, 32'hDEAD_BEEF});
        drive_m(0, 0, 0, 0, 0, 0);
        run_cycle();
        chk("t1_resp", 64'(ctrl_vec()), 64'(9'b1_00_10_0000));
        run_cycle();
        chk("t1_idle", 64'(ctrl_vec()), 64'd0);

        // 2: M1 IO read, data presented during ISSUE only
        drive_m(1, 1, 0, 1, 32'hFFFF_0008, 32'd0);
        bus_if.bus_dout = 32'hA5A5_A5A5;
        run_cycle();
        bus_if.bus_dout = 32'h0000_005A;
        chk("t2_issue", 64'(ctrl_vec()), 64'(9'b1_01_00_0010));
        drive_m(1, 0, 0, 0, 0, 0);
        run_cycle();
        bus_if.bus_dout = 32'hA5A5_A5A5;
        chk("t2_resp", 64'(ctrl_vec()), 64'(9'b1_00_01_0000));
        chk("t2_rdata", 64'(bus_if.m1_rdata), 64'h5A);
        run_cycle();

        // 3: both masters hold requests for 12 cycles
        drive_m(0, 1, 1, 0, 32'h0000_0020, 32'h1111_0000);
        drive_m(1, 1, 1, 0, 32'h0000_0024, 32'h2222_0000);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t3_gnt%0d", i), 64'({bus_if.m0_gnt, bus_if.m1_gnt}),
                64'({(i % 3 == 1) && (PRIO_MODE != 0 || (i / 3) % 2 == 0),
                     (i % 3 == 1) && PRIO_MODE == 0 && (i / 3) % 2 == 1}));
            run_cycle();
        end
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        run_cycle();
        run_cycle();
        run_cycle();

        // 4: M0 memory read, data valid only in the last wait cycle
        drive_m(0, 1, 0, 1, 32'h0000_0100, 32'd0);
        run_cycle();
        chk("t4_issue", 64'(ctrl_vec()), 64'(9'b1_10_00_1000));
        drive_m(0, 0, 0, 0, 0, 0);
        run_cycle();
        chk("t4_wait1", 64'(ctrl_vec()), 64'(9'b1_00_00_1000));
        run_cycle();
        bus_if.bus_dout = 32'h1234_5678;
        chk("t4_wait2", 64'(ctrl_vec()), 64'(9'b1_00_00_1000));
        run_cycle();
        bus_if.bus_dout = 32'hA5A5_A5A5;
        chk("t4_resp", 64'(ctrl_vec()), 64'(9'b1_00_10_0000));
        chk("t4_rdata", 64'(bus_if.m0_rdata), 64'h1234_5678);
        run_cycle();

        // 5: asynchronous reset during WAIT, M1 pending
        drive_m(0, 1, 0, 1, 32'h0000_0200, 32'd0);
        run_cycle();
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 1, 1, 0, 32'h0000_0300, 32'h0000_0077);
        run_cycle();
        rst = 1'b1;
        #1;
        chk("t5_async_ctrl", 64'(ctrl_vec()), 64'd0);
        chk("t5_async_rdata", 64'(bus_if.m0_rdata), 64'd0);
        run_cycle();
        rst = 1'b0;
        run_cycle();
        chk("t5_m1_first", 64'(ctrl_vec()), 64'(9'b1_01_00_0100));
        drive_m(1, 0, 0, 0, 0, 0);
        run_cycle();
        run_cycle();
`ifdef MEMIO_ARB_PERF_EN
        chk("t6_perf", 64'({perf_m0, perf_m1}), 64'({16'd0, 16'd1}));
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus_if.bus_dout = $urandom;
            rand_master(0);
            rand_master(1);
            run_cycle();
        end
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
